// File: rtl/vga_sync.sv
// vga_sync: VGA timing generator. Derives a half-rate pixel enable from the
// system clock and runs horizontal/vertical position counters. Sync, blanking
// and position outputs are all registered and change together, so downstream
// stages sampling while vga_clock is 0 see a consistent pixel.
module vga_sync #(
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_R_BORDER = 16,
  parameter int unsigned H_RETRACE  = 96,
  parameter int unsigned H_L_BORDER = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_T_BORDER = 10,
  parameter int unsigned V_RETRACE  = 2,
  parameter int unsigned V_B_BORDER = 33
) (
  input  logic       clock,
  input  logic       reset,
  output logic       vga_clock,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       new_frame,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_R_BORDER + H_RETRACE + H_L_BORDER;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_T_BORDER + V_RETRACE + V_B_BORDER;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VISIBLE    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VISIBLE    = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_R_BORDER);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_R_BORDER + H_RETRACE - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_T_BORDER);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_T_BORDER + V_RETRACE - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("vga_sync: line or frame total does not fit the 10-bit counters");
  end

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       frame_wrap;

  // Next pixel position; counters step only on the vga_clock 1->0 edge.
  always_comb begin
    x_next     = x;
    y_next     = y;
    frame_wrap = 1'b0;
    if (vga_clock) begin
      if (x == H_LAST) begin
        x_next = '0;
        if (y == V_LAST) begin
          y_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          y_next = y + 10'd1;
        end
      end else begin
        x_next = x + 10'd1;
      end
    end
  end

  // Register position together with syncs decoded from the next position,
  // so sync/blanking carry no skew relative to x/y.
  always_ff @(posedge clock) begin
    if (reset) begin
      vga_clock <= 1'b0;
      x         <= '0;
      y         <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      video_on  <= 1'b1;
      new_frame <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vga_clock <= ~vga_clock;
      x         <= x_next;
      y         <= y_next;
      hsync     <= !((x_next >= H_SYNC_FIRST) && (x_next <= H_SYNC_LAST));
      vsync     <= !((y_next >= V_SYNC_FIRST) && (y_next <= V_SYNC_LAST));
      video_on  <= (x_next < H_VISIBLE) && (y_next < V_VISIBLE);
      new_frame <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed checks of vga_sync. One instance uses the default
// 640x480 timing for reset/startup and horizontal boundaries; a second uses a
// tiny 8x7 raster (display 4x3, hsync x=5..6, vsync y=4..5) so whole frames
// and the 256-frame counter wrap fit in a short run.
module tb_vga_sync;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  logic       d_vga_clock, d_hsync, d_vsync, d_video_on, d_new_frame;
  logic [9:0] d_x, d_y;
  logic [7:0] d_frame_cnt;

  logic       s_vga_clock, s_hsync, s_vsync, s_video_on, s_new_frame;
  logic [9:0] s_x, s_y;
  logic [7:0] s_frame_cnt;

  vga_sync dut_def (
    .clock(clock), .reset(reset), .vga_clock(d_vga_clock), .hsync(d_hsync),
    .vsync(d_vsync), .video_on(d_video_on), .x(d_x), .y(d_y),
    .new_frame(d_new_frame), .frame_cnt(d_frame_cnt)
  );

  vga_sync #(
    .H_DISPLAY(4), .H_R_BORDER(1), .H_RETRACE(2), .H_L_BORDER(1),
    .V_DISPLAY(3), .V_T_BORDER(1), .V_RETRACE(2), .V_B_BORDER(1)
  ) dut_small (
    .clock(clock), .reset(reset), .vga_clock(s_vga_clock), .hsync(s_hsync),
    .vsync(s_vsync), .video_on(s_video_on), .x(s_x), .y(s_y),
    .new_frame(s_new_frame), .frame_cnt(s_frame_cnt)
  );

  // Packed view: {vga_clock, x, y, hsync, vsync, video_on, new_frame, frame_cnt}
  logic [32:0] d_st, s_st;
  assign d_st = {d_vga_clock, d_x, d_y, d_hsync, d_vsync, d_video_on, d_new_frame, d_frame_cnt};
  assign s_st = {s_vga_clock, s_x, s_y, s_hsync, s_vsync, s_video_on, s_new_frame, s_frame_cnt};

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned edges  = 0;

  function automatic logic [32:0] mk(input logic v, input logic [9:0] xx, input logic [9:0] yy,
                                     input logic hs, input logic vs, input logic vo,
                                     input logic nf, input logic [7:0] fc);
    return {v, xx, yy, hs, vs, vo, nf, fc};
  endfunction

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clock);
    edges += n;
  endtask

  task automatic do_reset(input int unsigned cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
    edges = 0;
  endtask

  task automatic test_reset;
    logic [32:0] rst_st;
    rst_st = mk(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (d_st !== rst_st) $display("FAIL reset_def[%0d]: got %h expected %h", i, d_st, rst_st);
      else passed++;
      checks++;
      if (s_st !== rst_st) $display("FAIL reset_small[%0d]: got %h expected %h", i, s_st, rst_st);
      else passed++;
    end
    reset = 1'b0;
    edges = 0;
  endtask

  task automatic test_startup(input string tag);
    logic [32:0] exp;
    logic        vg[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [9:0]  xs[4] = '{10'd0, 10'd1, 10'd1, 10'd2};
    for (int i = 0; i < 4; i++) begin
      step(1);
      exp = mk(vg[i], xs[i], 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      checks++;
      if (d_st !== exp) $display("FAIL %s_def[%0d]: got %h expected %h", tag, i, d_st, exp);
      else passed++;
      checks++;
      if (s_st !== exp) $display("FAIL %s_small[%0d]: got %h expected %h", tag, i, s_st, exp);
      else passed++;
    end
  endtask

  task automatic test_hline;
    int unsigned e[11];
    logic [32:0] ex[11];
    e[0]  = 1278; ex[0]  = mk(1'b0, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    e[1]  = 1279; ex[1]  = mk(1'b1, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    e[2]  = 1280; ex[2]  = mk(1'b0, 10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    e[3]  = 1310; ex[3]  = mk(1'b0, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    e[4]  = 1311; ex[4]  = mk(1'b1, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    e[5]  = 1312; ex[5]  = mk(1'b0, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    e[6]  = 1502; ex[6]  = mk(1'b0, 10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    e[7]  = 1504; ex[7]  = mk(1'b0, 10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    e[8]  = 1598; ex[8]  = mk(1'b0, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    e[9]  = 1599; ex[9]  = mk(1'b1, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    e[10] = 1600; ex[10] = mk(1'b0, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 11; i++) begin
      step(e[i] - edges);
      checks++;
      if (d_st !== ex[i]) $display("FAIL hline[edge %0d]: got %h expected %h", e[i], d_st, ex[i]);
      else passed++;
    end
  endtask

  task automatic test_mid_reset;
    logic [32:0] exp_d, exp_s, rst_st;
    rst_st = mk(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    do_reset(2);
    step(39);
    exp_d = mk(1'b1, 10'd19, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    exp_s = mk(1'b1, 10'd3,  10'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    checks++;
    if (d_st !== exp_d) $display("FAIL midrst_pre_def: got %h expected %h", d_st, exp_d);
    else passed++;
    checks++;
    if (s_st !== exp_s) $display("FAIL midrst_pre_small: got %h expected %h", s_st, exp_s);
    else passed++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    edges = 0;
    checks++;
    if (d_st !== rst_st) $display("FAIL midrst_def: got %h expected %h", d_st, rst_st);
    else passed++;
    checks++;
    if (s_st !== rst_st) $display("FAIL midrst_small: got %h expected %h", s_st, rst_st);
    else passed++;
    test_startup("restart");
  endtask

  task automatic test_small_frame;
    logic        hs_tab[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        vox_tab[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        vs_tab[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        voy_tab[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [32:0] exp, prev;
    logic        prev_hs;
    int unsigned vid_cycles = 0;
    int unsigned hs_falls = 0;
    int unsigned px, py;
    do_reset(2);
    prev = mk(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    prev_hs = s_hsync;
    for (int p = 0; p < 56; p++) begin
      if (p > 0) begin
        step(1);
        exp = prev;
        exp[32] = 1'b1;
        checks++;
        if (s_st !== exp) $display("FAIL frame_hold[p=%0d]: got %h expected %h", p, s_st, exp);
        else passed++;
        if (prev_hs && !s_hsync) hs_falls++;
        prev_hs = s_hsync;
        step(1);
      end
      px = p % 8;
      py = p / 8;
      exp = mk(1'b0, 10'(px), 10'(py), hs_tab[px], vs_tab[py], vox_tab[px] & voy_tab[py], 1'b0, 8'd0);
      checks++;
      if (s_st !== exp) $display("FAIL frame_pos[p=%0d]: got %h expected %h", p, s_st, exp);
      else passed++;
      if (prev_hs && !s_hsync) hs_falls++;
      prev_hs = s_hsync;
      if (s_video_on && !s_vga_clock) vid_cycles++;
      prev = exp;
    end
    step(1);
    if (prev_hs && !s_hsync) hs_falls++;
    step(1);
    if (!s_hsync) hs_falls++;
    exp = mk(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1);
    checks++;
    if (s_st !== exp || edges != 112) $display("FAIL frame_wrap[edge %0d]: got %h expected %h at edge 112", edges, s_st, exp);
    else passed++;
    step(1);
    exp = mk(1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
    checks++;
    if (s_st !== exp) $display("FAIL new_frame_fall: got %h expected %h", s_st, exp);
    else passed++;
    checks++;
    if (vid_cycles != 12) $display("FAIL video_cycles: got %0d expected 12", vid_cycles);
    else passed++;
    checks++;
    if (hs_falls != 7) $display("FAIL hsync_falls: got %0d expected 7", hs_falls);
    else passed++;
  endtask

  task automatic test_frame_cnt_wrap;
    logic [32:0] exp;
    step(255 * 112 - edges);
    exp = mk(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd255);
    checks++;
    if (s_st !== exp) $display("FAIL frame_cnt_255: got %h expected %h", s_st, exp);
    else passed++;
    step(112);
    exp = mk(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
    checks++;
    if (s_st !== exp) $display("FAIL frame_cnt_wrap: got %h expected %h", s_st, exp);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_startup("startup");
    test_hline();
    test_mid_reset();
    test_small_frame();
    test_frame_cnt_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
